// File: rtl/mac_accum_stage.sv
// mac_accum_stage: 8x8 multiply-accumulate over IN_LAST-terminated groups with a valid/ready result port.
module Multiplier_7_0_7_000 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  logic [15:0] s, c, pp, t, g, p;
  // Carry-save array reduction of the partial products into a sum/carry pair.
  always_comb begin
    s = '0;
    c = '0;
    pp = '0;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      pp = b_i[i] ? (16'(a_i) << i) : '0;
      t = s ^ c ^ pp;
      c = ((s & c) | (s & pp) | (c & pp)) << 1;
      s = t;
    end
  end
  // Kogge-Stone prefix tree resolves the final carries.
  always_comb begin
    g = s & c;
    p = s ^ c;
    for (int l = 0; l < 4; l++) begin
      g = g | (p & (g << (1 << l)));
      p = p & (p << (1 << l));
    end
    p_o = s ^ c ^ (g << 1);
  end
endmodule

module mac_accum_stage #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [7:0]       IN1,
  input  logic [7:0]       IN2,
  input  logic             IN_LAST,
  input  logic             ACC_CLR,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [ACC_W-1:0] OUT_ACC,
  output logic [CNT_W-1:0] OUT_CNT,
  output logic             OUT_OVF
);
  typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_e;
  state_e state_q, state_d;
  logic rdy_q, s1_v_q, s1_l_q, s2_v_q, s2_l_q, l3_q, ovf_q, ovf_d, take, clr;
  logic [7:0] a_q, b_q;
  logic [15:0] prod, prod_q;
  logic [ACC_W:0] sum;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  Multiplier_7_0_7_000 u_mul (.a_i(a_q), .b_i(b_q), .p_o(prod));
  assign IN_READY = rdy_q;
  assign take = IN_VALID & rdy_q;
  assign clr = (state_q == ACCUM) & ACC_CLR;
  assign sum = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (s2_v_q) begin
      acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
      cnt_d = cnt_q + CNT_W'(cnt_q != '1);
      ovf_d = ovf_q | sum[ACC_W];
    end
    if (clr || (state_q == HOLD && OUT_READY)) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
    state_d = (state_q == ACCUM && take && IN_LAST) ? FLUSH :
              (state_q == FLUSH && l3_q)            ? HOLD  :
              (state_q == HOLD && OUT_READY)        ? ACCUM : state_q;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ACCUM;
      rdy_q     <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_l_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      s2_v_q    <= 1'b0;
      s2_l_q    <= 1'b0;
      prod_q    <= '0;
      l3_q      <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_ACC   <= '0;
      OUT_CNT   <= '0;
      OUT_OVF   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= state_d == ACCUM;
      s1_v_q  <= take;
      s1_l_q  <= take & IN_LAST;
      if (take) begin
        a_q <= IN1;
        b_q <= IN2;
      end
      s2_v_q <= s1_v_q & ~clr;
      s2_l_q <= s1_l_q & ~clr;
      if (s1_v_q) prod_q <= prod;
      l3_q  <= s2_l_q;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      OUT_VALID <= state_d == HOLD;
      if (state_q == FLUSH && l3_q) begin
        OUT_ACC <= acc_q;
        OUT_CNT <= cnt_q;
        OUT_OVF <= ovf_q;
      end
    end
  end
endmodule
